// File: rtl/fft_mod12_requant.sv
// fft_mod12_requant: takes the mod12 twiddle multiplier's 25-bit complex
// products and rounds them to 16-bit signed samples. Each sample is rounded
// half-up and clamped. The samples pass through one stage register and a
// small FIFO, then go to the next butterfly stage over valid/ready.
//
// Ports:
//   clk, rstn, clr        clock, sync active-low reset, sync clear
//   in_valid              product beat valid (no backpressure)
//   din_{R,Q}_{add,sub}   LANES x IN_W signed products
//   out_valid/out_ready   FIFO head handshake
//   dout_{R,Q}_{add,sub}  LANES x OUT_W signed samples at FIFO head
//   out_last              head is the final beat of a frame
//   sat_flag, ovf_flag    sticky saturation / dropped-beat flags
//   level                 FIFO occupancy
module fft_mod12_requant #(
    parameter int unsigned LANES = 8,
    parameter int unsigned IN_W  = 25,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BEATS = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  din_R_add [LANES],
    input  logic signed [IN_W-1:0]  din_Q_add [LANES],
    input  logic signed [IN_W-1:0]  din_R_sub [LANES],
    input  logic signed [IN_W-1:0]  din_Q_sub [LANES],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout_R_add [LANES],
    output logic signed [OUT_W-1:0] dout_Q_add [LANES],
    output logic signed [OUT_W-1:0] dout_R_sub [LANES],
    output logic signed [OUT_W-1:0] dout_Q_sub [LANES],
    output logic                    out_last,
    output logic                    sat_flag,
    output logic                    ovf_flag,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned NVAL   = 4 * LANES;
    localparam int unsigned BEAT_W = NVAL * OUT_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] QMIN = ~QMAX;

    // Round half-up and clamp; the MSB of the result flags a clamp.
    function automatic logic [OUT_W:0] requant(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] q;
        sum = (IN_W+1)'(x) + RND;
        q   = sum >>> SHIFT;
        if (q > QMAX) begin
            return {1'b1, OUT_W'(QMAX)};
        end
        if (q < QMIN) begin
            return {1'b1, OUT_W'(QMIN)};
        end
        return {1'b0, q[OUT_W-1:0]};
    endfunction

    logic signed [IN_W-1:0] din_all [NVAL];
    logic [BEAT_W-1:0]      rq_data;
    logic                   rq_sat;
    logic [OUT_W:0]         rq_tmp;

    logic                   s1_valid;
    logic                   s1_last;
    logic                   s1_sat;
    logic [BEAT_W-1:0]      s1_data;
    logic [CNT_W-1:0]       cnt;

    logic [BEAT_W:0]        mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       next_rd;
    logic [LVL_W-1:0]       level_nxt;
    logic [BEAT_W:0]        head_nxt;
    logic [BEAT_W-1:0]      dout_q;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic                   rst;

    assign rst = !rstn || clr;

    // Flatten the four branches into one index space: R_add, Q_add, R_sub, Q_sub.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            din_all[l]           = din_R_add[l];
            din_all[LANES + l]   = din_Q_add[l];
            din_all[2*LANES + l] = din_R_sub[l];
            din_all[3*LANES + l] = din_Q_sub[l];
        end
    end

    // Requantize all values of the current input beat.
    always_comb begin
        rq_data = '0;
        rq_sat  = 1'b0;
        rq_tmp  = '0;
        for (int i = 0; i < NVAL; i++) begin
            rq_tmp                   = requant(din_all[i]);
            rq_data[i*OUT_W +: OUT_W] = rq_tmp[OUT_W-1:0];
            rq_sat                   = rq_sat | rq_tmp[OUT_W];
        end
    end

    // FIFO control. When full, a push goes through only if a pop happens on the same edge.
    always_comb begin
        full      = (level == LVL_W'(DEPTH));
        pop       = out_valid && out_ready;
        push_ok   = s1_valid && (!full || pop);
        drop      = s1_valid && full && !pop;
        level_nxt = level + LVL_W'(push_ok) - LVL_W'(pop);
        next_rd   = rd_ptr + PTR_W'(pop);
        // The entry written this edge becomes head when it lands at the next read slot.
        if (push_ok && (wr_ptr == next_rd)) begin
            head_nxt = {s1_last, s1_data};
        end else begin
            head_nxt = mem[next_rd];
        end
    end

    // FIFO storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= {s1_last, s1_data};
        end
    end

    // Beat counter, stage register S1, pointers, head register and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sat    <= 1'b0;
            s1_data   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout_q    <= '0;
            sat_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            if (in_valid) begin
                cnt <= (cnt == CNT_W'(BEATS - 1)) ? '0 : cnt + CNT_W'(1);
            end
            s1_valid <= in_valid;
            s1_last  <= in_valid && (cnt == CNT_W'(BEATS - 1));
            s1_sat   <= in_valid && rq_sat;
            s1_data  <= rq_data;

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= next_rd;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // Head data holds its last value when the FIFO drains empty.
            if (level_nxt != '0) begin
                {out_last, dout_q} <= head_nxt;
            end

            sat_flag <= sat_flag | s1_sat;
            ovf_flag <= ovf_flag | drop;
        end
    end

    // Unpack the registered head into the per-branch output arrays.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            dout_R_add[l] = dout_q[l*OUT_W +: OUT_W];
            dout_Q_add[l] = dout_q[(LANES + l)*OUT_W +: OUT_W];
            dout_R_sub[l] = dout_q[(2*LANES + l)*OUT_W +: OUT_W];
            dout_Q_sub[l] = dout_q[(3*LANES + l)*OUT_W +: OUT_W];
        end
    end

endmodule

// File: tb/tb_fft_mod12_requant.sv
// tb_fft_mod12_requant: directed and random stimulus for fft_mod12_requant.
// A queue-based reference model predicts every output each cycle.
module tb_fft_mod12_requant;

    localparam int LANES = 8;
    localparam int DEPTH = 4;
    localparam int BEATS = 64;
    localparam int NVAL  = 4 * LANES;

    logic clk = 1'b0;
    logic rstn, clr, in_valid, out_ready;
    logic signed [24:0] din_ra [LANES];
    logic signed [24:0] din_qa [LANES];
    logic signed [24:0] din_rs [LANES];
    logic signed [24:0] din_qs [LANES];
    logic signed [15:0] dout_ra [LANES];
    logic signed [15:0] dout_qa [LANES];
    logic signed [15:0] dout_rs [LANES];
    logic signed [15:0] dout_qs [LANES];
    logic out_valid, out_last, sat_flag, ovf_flag;
    logic [2:0] level;

    fft_mod12_requant dut (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid),
        .din_R_add(din_ra), .din_Q_add(din_qa), .din_R_sub(din_rs), .din_Q_sub(din_qs),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_R_add(dout_ra), .dout_Q_add(dout_qa), .dout_R_sub(dout_rs), .dout_Q_sub(dout_qs),
        .out_last(out_last), .sat_flag(sat_flag), .ovf_flag(ovf_flag), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              last;
        logic [31:0][15:0] v;
    } beat_t;

    // Reference model state
    beat_t q[$];
    beat_t s1;
    logic  s1v, s1sat, m_sat, m_ovf, fresh;
    int    cnt;

    // Observed transfers
    longint obs_v0[$];
    longint obs_v1[$];
    int     obs_last_idx[$];
    int     n_xfer;
    logic   cand_valid, cand_last;
    longint cand_v0, cand_v1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // floor((x + 128) / 256), then clamp to int16; bit 16 marks a clamp
    function automatic logic [16:0] ref_rq(input longint x);
        longint s, y;
        s = x + 128;
        y = s / 256;
        if (s % 256 < 0) y = y - 1;
        if (y > 32767) return {1'b1, 16'h7fff};
        if (y < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(y)};
    endfunction

    function automatic longint in_val(input int i);
        case (i / LANES)
            0: return longint'(din_ra[i % LANES]);
            1: return longint'(din_qa[i % LANES]);
            2: return longint'(din_rs[i % LANES]);
            default: return longint'(din_qs[i % LANES]);
        endcase
    endfunction

    function automatic longint out_val(input int i);
        case (i / LANES)
            0: return longint'(dout_ra[i % LANES]);
            1: return longint'(dout_qa[i % LANES]);
            2: return longint'(dout_rs[i % LANES]);
            default: return longint'(dout_qs[i % LANES]);
        endcase
    endfunction

    // mode 0: zeros, 1: small random (no clamp), 2: full-range random
    task automatic set_beat(input int mode);
        for (int l = 0; l < LANES; l++) begin
            din_ra[l] = 25'($urandom);
            din_qa[l] = 25'($urandom);
            din_rs[l] = 25'($urandom);
            din_qs[l] = 25'($urandom);
            if (mode == 0) begin
                din_ra[l] = '0; din_qa[l] = '0; din_rs[l] = '0; din_qs[l] = '0;
            end else if (mode == 1) begin
                din_ra[l] = din_ra[l] >>> 2; din_qa[l] = din_qa[l] >>> 2;
                din_rs[l] = din_rs[l] >>> 2; din_qs[l] = din_qs[l] >>> 2;
            end
        end
    endtask

    // One clock edge of the behavioural model, using the inputs currently applied.
    task automatic model_step();
        int   sz;
        logic pop;
        logic [16:0] r;
        if (!rstn || clr) begin
            q.delete();
            s1v = 0; s1sat = 0; cnt = 0; m_sat = 0; m_ovf = 0; fresh = 1;
        end else begin
            sz  = q.size();
            pop = (sz > 0) && out_ready;
            if (s1v && s1sat) m_sat = 1;
            if (pop) void'(q.pop_front());
            if (s1v) begin
                if (sz == DEPTH && !pop) m_ovf = 1;
                else q.push_back(s1);
            end
            s1v   = in_valid;
            s1sat = 0;
            if (in_valid) begin
                for (int i = 0; i < NVAL; i++) begin
                    r = ref_rq(in_val(i));
                    s1.v[i] = r[15:0];
                    if (r[16]) s1sat = 1;
                end
                s1.last = (cnt == BEATS - 1);
                cnt = (cnt + 1) % BEATS;
            end
            if (q.size() > 0) fresh = 0;
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("sat_flag", sat_flag, m_sat);
        chk("ovf_flag", ovf_flag, m_ovf);
        if (q.size() > 0) begin
            chk("out_last", out_last, q[0].last);
            for (int i = 0; i < NVAL; i++)
                chk($sformatf("dout%0d", i), out_val(i), longint'($signed(q[0].v[i])));
        end else if (fresh) begin
            chk("last_rst", out_last, 0);
            for (int i = 0; i < NVAL; i++)
                chk($sformatf("dout_rst%0d", i), out_val(i), 0);
        end
        cand_valid = out_valid;
        cand_last  = out_last;
        cand_v0    = longint'(dout_ra[0]);
        cand_v1    = longint'(dout_ra[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstn && !clr && cand_valid && out_ready) begin
            obs_v0.push_back(cand_v0);
            obs_v1.push_back(cand_v1);
            if (cand_last) obs_last_idx.push_back(n_xfer);
            n_xfer++;
        end
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_obs();
        obs_v0.delete(); obs_v1.delete(); obs_last_idx.delete(); n_xfer = 0;
    endtask

    task automatic do_clr();
        clr = 1; in_valid = 0;
        cycle();
        clr = 0;
        clear_obs();
    endtask

    task automatic beat_lane0(input longint v);
        set_beat(0);
        din_ra[0] = 25'(v);
        in_valid  = 1;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) cycle();
    endtask

    longint rnd_in [5]  = '{128, 127, -128, -129, 384};
    longint rnd_exp [5] = '{1, 0, 0, -1, 2};

    initial begin
        rstn = 0; clr = 0; in_valid = 0; out_ready = 0;
        set_beat(0);
        s1 = '0; s1v = 0; s1sat = 0; m_sat = 0; m_ovf = 0; fresh = 1; cnt = 0;
        cand_valid = 0; cand_last = 0; cand_v0 = 0; cand_v1 = 0;
        clear_obs();

        repeat (2) cycle();
        rstn = 1;

        // Rounding
        out_ready = 1;
        for (int k = 0; k < 5; k++) beat_lane0(rnd_in[k]);
        idle(4);
        chk("rnd_count", obs_v0.size(), 5);
        for (int k = 0; k < 5 && k < obs_v0.size(); k++) chk("rnd_val", obs_v0[k], rnd_exp[k]);
        chk("rnd_sat", sat_flag, 0);

        // Saturation, stickiness, clear
        clear_obs();
        set_beat(0);
        din_ra[0] = 25'(8388607);
        din_ra[1] = 25'(-16777216);
        in_valid  = 1;
        cycle();
        idle(4);
        chk("sat_pos", obs_v0.size() > 0 ? obs_v0[0] : 0, 32767);
        chk("sat_neg", obs_v1.size() > 0 ? obs_v1[0] : 0, -32768);
        chk("sat_set", sat_flag, 1);
        for (int k = 0; k < 3; k++) begin set_beat(1); in_valid = 1; cycle(); end
        idle(4);
        chk("sat_sticky", sat_flag, 1);
        do_clr();
        chk("sat_clr", sat_flag, 0);

        // Frame marking over 130 beats
        out_ready = 1;
        for (int k = 0; k < 130; k++) begin set_beat(1); in_valid = 1; cycle(); end
        idle(4);
        chk("frame_count", n_xfer, 130);
        chk("frame_nlast", obs_last_idx.size(), 2);
        if (obs_last_idx.size() == 2) begin
            chk("frame_last0", obs_last_idx[0], 63);
            chk("frame_last1", obs_last_idx[1], 127);
        end

        // Backpressure and overflow
        do_clr();
        out_ready = 0;
        for (int k = 1; k <= 6; k++) beat_lane0(k * 256);
        idle(3);
        chk("bp_level", level, 4);
        chk("bp_ovf", ovf_flag, 1);
        out_ready = 1;
        idle(6);
        chk("bp_count", obs_v0.size(), 4);
        for (int k = 0; k < 4 && k < obs_v0.size(); k++) chk("bp_val", obs_v0[k], k + 1);

        // Full FIFO with simultaneous push and pop
        do_clr();
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin set_beat(1); in_valid = 1; cycle(); end
        idle(2);
        chk("full_fill", level, 4);
        set_beat(1); in_valid = 1; cycle();
        out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            set_beat(1); in_valid = 1; cycle();
            chk("full_lvl", level, 4);
            chk("full_ovf", ovf_flag, 0);
        end
        idle(8);

        // Reset mid-frame
        do_clr();
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin set_beat(1); in_valid = 1; cycle(); end
        rstn = 0; in_valid = 0;
        cycle();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_dout", longint'(dout_ra[0]), 0);
        rstn = 1;
        clear_obs();
        for (int k = 0; k < 64; k++) begin set_beat(1); in_valid = 1; cycle(); end
        idle(4);
        chk("rst_count", n_xfer, 64);
        chk("rst_nlast", obs_last_idx.size(), 1);
        if (obs_last_idx.size() == 1) chk("rst_last", obs_last_idx[0], 63);

        // Random traffic
        do_clr();
        for (int k = 0; k < 600; k++) begin
            set_beat(($urandom % 8 == 0) ? 2 : 1);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            clr       = ($urandom % 150) == 0;
            cycle();
            clr = 0;
        end
        out_ready = 1;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
